round_ctrl: RTL and testbench
=============================

// Module: round_ctrl
// PURPOSE
//  Clocked, parametrised round sequencer for the reflex trainer. Replaces the
//  single-round latch with a multi-round game: a trigger edge starts round 0.
//  Each round runs ROUND_SEC seconds, followed by a GAP_SEC inter-round gap.
//  The game ends after NUM_ROUNDS rounds. Feeds start / elapsed_time /
//  round_idx to the scoring and display logic.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per second (tick prescaler period)
//  ROUND_SEC  30          round length in seconds (>=1)
//  GAP_SEC    2           inter-round gap in seconds (>=1)
//  NUM_ROUNDS 3           rounds per game (>=1)
//  TW         $clog2(ROUND_SEC+1)     elapsed_time width (derived)
//  RW         max(1,$clog2(NUM_ROUNDS)) round_idx width (derived)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-high reset
//  trigger       in   1   player button, already synchronised/debounced to clk
//  abort         in   1   synchronous abort, returns to IDLE
//  pause         in   1   freeze timing (present only with ROUND_PAUSE_EN)
//  start         out  1   high while a round is ACTIVE
//  elapsed_time  out  TW  whole seconds elapsed in the current round
//  round_idx     out  RW  current round number, 0-based
//  round_done    out  1   one-cycle pulse when a round expires
//  game_over     out  1   high in DONE
//  state         out  2   FSM state (encoding from round_pkg)
// BEHAVIOUR
//  - All outputs registered. On rst: state=IDLE, all outputs 0, prescaler 0,
//    trigger_q 0. Reset asserted mid-round aborts immediately; no pulses issued.
//  - Edge detect: trig_rise = trigger & ~trigger_q; a held trigger counts once.
//  - Prescaler: counts 0..TICK_DIV-1 and asserts sec_tick when count ==
//    TICK_DIV-1. Cleared on every entry to ACTIVE or GAP, so each second is
//    exactly TICK_DIV cycles.
//  - IDLE: on trig_rise -> ACTIVE next cycle, round_idx=0, elapsed_time=0.
//    Latency: trigger edge in cycle N -> start=1 in cycle N+1.
//  - ACTIVE: start=1. elapsed_time increments on each sec_tick.
//    - On the tick that would make elapsed_time==ROUND_SEC: elapsed_time
//      becomes ROUND_SEC, start=0, and round_done=1 for exactly one cycle.
//    - Next state is DONE if round_idx==NUM_ROUNDS-1, otherwise GAP.
//    - trig_rise is ignored (no restart, no extension).
//  - GAP: start=0; elapsed_time holds ROUND_SEC. After GAP_SEC sec_ticks ->
//    ACTIVE with round_idx+1 and elapsed_time=0.
//  - DONE: game_over=1; round_idx and elapsed_time hold.
//    - trig_rise -> ACTIVE as a new game: round_idx=0, game_over=0.
//  - abort in any non-IDLE state -> IDLE next cycle, all outputs 0, no
//    round_done.
//    - abort wins over a simultaneous sec_tick or trig_rise.
//    - abort in IDLE is a no-op.
//  - Never wraps: elapsed_time saturates at ROUND_SEC; round_idx never exceeds
//    NUM_ROUNDS-1.
// CONFIGURATION
//  ROUND_PAUSE_EN defined:
//    - pause port exists. While pause=1 in ACTIVE or GAP, the prescaler and
//      elapsed_time freeze, and start keeps its value.
//    - abort still acts during pause.
//    - Timing resumes from the frozen count on the cycle pause=0.
//  ROUND_PAUSE_EN undefined: no pause port; timing never freezes.
// STRUCTURE
//  - round_pkg: state typedef/encoding (IDLE=0, ACTIVE=1, GAP=2, DONE=3) and
//    the shared TW/RW width functions.
//  - Sub-module sec_tick_gen #(TICK_DIV) (clk, rst, clr, hold, sec_tick):
//    the prescaler; hold is tied 0 without ROUND_PAUSE_EN.
//  - FSM and counters live in round_ctrl.
// TESTING  (TICK_DIV=4, ROUND_SEC=3, GAP_SEC=1, NUM_ROUNDS=2)
//  - rst release, trigger pulse at cycle 10 -> start=1 cycles 11..22;
//    elapsed_time=1 at cycle 15; round_done=1 only at cycle 23.
//  - Continue -> GAP cycles 23..26; round_idx=1 with start=1 cycles 27..38;
//    round_done at cycle 39; game_over=1 from cycle 39 on.
//  - trigger held high 20 cycles in IDLE -> exactly one game starts.
//  - Re-trigger during ACTIVE -> ignored.
//  - Trigger in DONE -> round_idx=0, game_over=0, start=1 next cycle.
//  - abort on the same cycle as the round-ending tick -> IDLE, round_done
//    stays 0, all outputs 0.
//  - rst pulse mid-GAP -> all outputs 0 immediately, asynchronously;
//    the next trigger starts round 0.
//  - ROUND_PAUSE_EN: pause=1 for 10 cycles inside round 0 -> start falls
//    10 cycles later (cycle 33); elapsed_time is frozen during pause.

Source files
------------

// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared state encoding and width helpers for the round sequencer
package round_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } round_state_t;

  function automatic int tw_f(input int round_sec);
    return $clog2(round_sec + 1);
  endfunction

  function automatic int rw_f(input int num_rounds);
    return (num_rounds <= 1) ? 1 : $clog2(num_rounds);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-second prescaler with synchronous clear and freeze
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic sec_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Gated by hold so a frozen terminal count cannot fire repeatedly.
  assign sec_tick = (count == LAST) && !hold;

endmodule

// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - multi-round game sequencer; ROUND_PAUSE_EN adds a pause input
module round_ctrl
  import round_pkg::*;
#(
  parameter  int TICK_DIV   = 50_000_000,
  parameter  int ROUND_SEC  = 30,
  parameter  int GAP_SEC    = 2,
  parameter  int NUM_ROUNDS = 3,
  localparam int TW         = tw_f(ROUND_SEC),
  localparam int RW         = rw_f(NUM_ROUNDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trigger,
  input  logic          abort,
`ifdef ROUND_PAUSE_EN
  input  logic          pause,
`endif
  output logic          start,
  output logic [TW-1:0] elapsed_time,
  output logic [RW-1:0] round_idx,
  output logic          round_done,
  output logic          game_over,
  output logic [1:0]    state
);

  localparam int GW = tw_f(GAP_SEC);

  round_state_t  cur;
  logic          trigger_q;
  logic [GW-1:0] gap_cnt;
  logic          trig_rise;
  logic          sec_tick;
  logic          timed;
  logic          last_round;
  logic          round_end;
  logic          gap_end;
  logic          clr;
  logic          hold;

  assign state      = cur;
  assign trig_rise  = trigger & ~trigger_q;
  assign timed      = (cur == ACTIVE) || (cur == GAP);
  assign last_round = (round_idx == RW'(NUM_ROUNDS - 1));
  assign round_end  = (cur == ACTIVE) && sec_tick && (elapsed_time == TW'(ROUND_SEC - 1));
  assign gap_end    = (cur == GAP) && sec_tick && (gap_cnt == GW'(GAP_SEC - 1));

  // Prescaler restarts on every entry into a timed phase so each second is whole.
  assign clr = !timed || (round_end && !last_round) || gap_end;

`ifdef ROUND_PAUSE_EN
  assign hold = pause && timed;
`else
  assign hold = 1'b0;
`endif

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .hold     (hold),
    .sec_tick (sec_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= IDLE;
      trigger_q    <= 1'b0;
      start        <= 1'b0;
      elapsed_time <= '0;
      round_idx    <= '0;
      round_done   <= 1'b0;
      game_over    <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      trigger_q  <= trigger;
      round_done <= 1'b0;
      if (abort && cur != IDLE) begin
        cur          <= IDLE;
        start        <= 1'b0;
        elapsed_time <= '0;
        round_idx    <= '0;
        game_over    <= 1'b0;
        gap_cnt      <= '0;
      end else begin
        case (cur)
          IDLE, DONE: begin
            if (trig_rise) begin
              cur          <= ACTIVE;
              start        <= 1'b1;
              elapsed_time <= '0;
              round_idx    <= '0;
              game_over    <= 1'b0;
              gap_cnt      <= '0;
            end
          end
          ACTIVE: begin
            if (round_end) begin
              elapsed_time <= TW'(ROUND_SEC);
              start        <= 1'b0;
              round_done   <= 1'b1;
              gap_cnt      <= '0;
              if (last_round) begin
                cur       <= DONE;
                game_over <= 1'b1;
              end else begin
                cur <= GAP;
              end
            end else if (sec_tick) begin
              elapsed_time <= elapsed_time + 1'b1;
            end
          end
          GAP: begin
            if (gap_end) begin
              cur          <= ACTIVE;
              start        <= 1'b1;
              elapsed_time <= '0;
              round_idx    <= round_idx + 1'b1;
              gap_cnt      <= '0;
            end else if (sec_tick) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: cur <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - randomized bench for round_ctrl against a cycle-count game model
module tb_round_ctrl;
  import round_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int ROUND_SEC  = 3;
  localparam int GAP_SEC    = 1;
  localparam int NUM_ROUNDS = 2;
  localparam int TW         = tw_f(ROUND_SEC);
  localparam int RW         = rw_f(NUM_ROUNDS);
`ifdef ROUND_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          trigger;
  logic          abort;
  logic          pause;
  logic          start;
  logic [TW-1:0] elapsed_time;
  logic [RW-1:0] round_idx;
  logic          round_done;
  logic          game_over;
  logic [1:0]    state;

  round_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .ROUND_SEC  (ROUND_SEC),
    .GAP_SEC    (GAP_SEC),
    .NUM_ROUNDS (NUM_ROUNDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .abort        (abort),
`ifdef ROUND_PAUSE_EN
    .pause        (pause),
`endif
    .start        (start),
    .elapsed_time (elapsed_time),
    .round_idx    (round_idx),
    .round_done   (round_done),
    .game_over    (game_over),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Game model: phases measured in raw clock cycles since phase entry.
  int  m_state;
  int  m_cyc;
  int  m_round;
  bit  m_done;
  bit  m_prev;

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_round = 0; m_done = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit t, input bit a, input bit p);
    bit rise;
    bit frozen;
    rise   = t && !m_prev;
    m_prev = t;
    m_done = 0;
    frozen = PAUSE_EN && p && (m_state == 1 || m_state == 2);
    if (a && m_state != 0) begin
      m_state = 0; m_cyc = 0; m_round = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (rise) begin
        m_state = 1; m_cyc = 0; m_round = 0;
      end
    end else if (!frozen) begin
      m_cyc++;
      if (m_state == 1 && m_cyc == ROUND_SEC * TICK_DIV) begin
        m_done  = 1;
        m_cyc   = 0;
        m_state = (m_round == NUM_ROUNDS - 1) ? 3 : 2;
      end else if (m_state == 2 && m_cyc == GAP_SEC * TICK_DIV) begin
        m_state = 1; m_cyc = 0; m_round++;
      end
    end
  endtask

  function automatic int exp_elapsed();
    case (m_state)
      1:       return m_cyc / TICK_DIV;
      2, 3:    return ROUND_SEC;
      default: return 0;
    endcase
  endfunction

  task automatic check_outputs();
    expect_eq("state", state, m_state);
    expect_eq("start", start, (m_state == 1));
    expect_eq("elapsed_time", elapsed_time, exp_elapsed());
    expect_eq("round_idx", round_idx, m_round);
    expect_eq("round_done", round_done, m_done);
    expect_eq("game_over", game_over, (m_state == 3));
  endtask

  task automatic step(input bit t, input bit a, input bit p);
    trigger = t; abort = a; pause = p;
    @(posedge clk);
    model_step(t, a, p);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit t, a, p;
    int guard;
    rst = 1'b1; trigger = 1'b0; abort = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Full two-round game: trigger at cycle 10, run past the final round.
    repeat (9) step(0, 0, 0);
    step(1, 0, 0);
    repeat (34) step(0, 0, 0);
    expect_eq("game_over_after_game", game_over, 1);

    // Trigger in DONE restarts; re-trigger during ACTIVE is ignored.
    step(1, 0, 0);
    expect_eq("restart_start", start, 1);
    expect_eq("restart_round", round_idx, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);

    // Abort to IDLE, then a long held trigger starts exactly one game.
    step(0, 1, 0);
    expect_eq("abort_state", state, 0);
    repeat (20) step(1, 0, 0);
    step(0, 0, 0);

    // Abort coincident with the round-ending tick.
    step(0, 1, 0);
    step(1, 0, 0);
    guard = 0;
    while (!(m_state == 1 && m_cyc == ROUND_SEC * TICK_DIV - 1) && guard < 100) begin
      step(0, 0, 0);
      guard++;
    end
    expect_eq("reach_round_end", guard < 100, 1);
    step(0, 1, 0);
    expect_eq("abort_no_done", round_done, 0);
    expect_eq("abort_idle", state, 0);

    // Asynchronous reset in the middle of a gap.
    step(1, 0, 0);
    guard = 0;
    while (m_state != 2 && guard < 100) begin
      step(0, 0, 0);
      guard++;
    end
    expect_eq("reach_gap", m_state, 2);
    step(0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0);
    expect_eq("post_reset_start", start, 1);
    expect_eq("post_reset_round", round_idx, 0);

`ifdef ROUND_PAUSE_EN
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    repeat (10) step(0, 0, 1);
    repeat (20) step(0, 0, 0);
`endif

    // Random play.
    t = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) t = ~t;
      a = ($urandom_range(0, 63) == 0);
      p = PAUSE_EN && ($urandom_range(0, 15) == 0);
      step(t, a, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
